// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle controller.
// Holds the 4-bit FSM state enum, the opcode and funct field constants,
// the aluop encodings and the ALU operation codes driven on alucontrol.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // Opcode field values
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Funct field values for R-type instructions
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // aluop encodings passed from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_aludec.sv
// aludec: combinational ALU control decoder.
// Ports:
//   aluop      in  2  operation class from the controller FSM
//   funct      in  6  funct field of the instruction register
//   alucontrol out 3  ALU operation code
module aludec
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            // aluop 11 is never produced by the FSM; treat it as add
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM controller for a multicycle MIPS-style datapath.
// Ports:
//   clk, reset (async, active-high)
//   op, funct      instruction fields; zero  ALU zero flag
//   iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca
//   alusrcb[1:0], pcsrc[1:0], pcen   datapath controls
//   alucontrol[2:0]                  ALU operation (from aludec)
//   state[3:0]                       current FSM state for debug
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: op is only looked at in DECODE and MEMADR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (op == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
                       state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore output decode: everything defaults to 0.
    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        aluop    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // zero only matters while branch is high, i.e. in BRANCH
    assign pcen  = pcwrite | (branch & zero);
    assign state = state_q;

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: self-checking bench for mc_controller.
module tb_mc_controller;
    import mc_pkg::*;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int n_pass  = 0;
    int n_total = 0;

    state_t exp_q[$];

    typedef struct {
        logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic       pcen;
        logic [2:0] alucontrol;
    } ctl_t;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .alucontrol (alucontrol),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Control table: what each state must drive.
    function automatic ctl_t exp_ctl(input state_t s, input logic [5:0] f, input logic z);
        ctl_t c;
        c = '{default: '0};
        c.alucontrol = 3'b010;
        case (s)
            S_FETCH:   begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcen = 1'b1; end
            S_DECODE:  c.alusrcb = 2'b11;
            S_MEMADR,
            S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMRD:   c.iord = 1'b1;
            S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
            S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            S_EXECUTE: begin
                c.alusrca = 1'b1;
                if (f == 6'b100010)      c.alucontrol = 3'b110;
                else if (f == 6'b100100) c.alucontrol = 3'b000;
                else if (f == 6'b100101) c.alucontrol = 3'b001;
                else if (f == 6'b101010) c.alucontrol = 3'b111;
                else                     c.alucontrol = 3'b010;
            end
            S_ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            S_ADDIWB:  c.regwrite = 1'b1;
            S_BRANCH:  begin
                c.alusrca = 1'b1; c.pcsrc = 2'b01; c.alucontrol = 3'b110; c.pcen = z;
            end
            S_JUMP:    begin c.pcsrc = 2'b10; c.pcen = 1'b1; end
            default:   ;
        endcase
        return c;
    endfunction

    task automatic compare_state(input state_t s);
        ctl_t c;
        c = exp_ctl(s, funct, zero);
        check("state",      32'(state),      32'(s));
        check("iord",       32'(iord),       32'(c.iord));
        check("memwrite",   32'(memwrite),   32'(c.memwrite));
        check("irwrite",    32'(irwrite),    32'(c.irwrite));
        check("regdst",     32'(regdst),     32'(c.regdst));
        check("memtoreg",   32'(memtoreg),   32'(c.memtoreg));
        check("regwrite",   32'(regwrite),   32'(c.regwrite));
        check("alusrca",    32'(alusrca),    32'(c.alusrca));
        check("alusrcb",    32'(alusrcb),    32'(c.alusrcb));
        check("pcsrc",      32'(pcsrc),      32'(c.pcsrc));
        check("pcen",       32'(pcen),       32'(c.pcen));
        check("alucontrol", 32'(alucontrol), 32'(c.alucontrol));
    endtask

    // Single compare process: under reset the outputs must be the FETCH
    // decode; otherwise each cycle consumes one expected state.
    always @(negedge clk) begin
        if (reset) begin
            compare_state(S_FETCH);
        end else if (exp_q.size() > 0) begin
            compare_state(exp_q.pop_front());
        end
    end

    // Expected state walk for one instruction, from its opcode alone.
    task automatic push_seq(input logic [5:0] o);
        exp_q.push_back(S_FETCH);
        exp_q.push_back(S_DECODE);
        case (o)
            6'b100011: begin exp_q.push_back(S_MEMADR); exp_q.push_back(S_MEMRD); exp_q.push_back(S_MEMWB); end
            6'b101011: begin exp_q.push_back(S_MEMADR); exp_q.push_back(S_MEMWR); end
            6'b000000: begin exp_q.push_back(S_EXECUTE); exp_q.push_back(S_ALUWB); end
            6'b001000: begin exp_q.push_back(S_ADDIEX); exp_q.push_back(S_ADDIWB); end
            6'b000100: exp_q.push_back(S_BRANCH);
            6'b000010: exp_q.push_back(S_JUMP);
            default:   ;
        endcase
    endtask

    // Entered at posedge+2 with the DUT in FETCH; returns the same way.
    // probe >= 0 adds a literal alucontrol/pcen check at that cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int expected_len, input int probe,
                             input logic [2:0] p_alu, input logic p_pcen, input bit scramble);
        int len;
        op    = o;
        funct = f;
        zero  = z;
        push_seq(o);
        len = exp_q.size();
        check("cycle_count", 32'(len), 32'(expected_len));
        for (int i = 0; i < len; i++) begin
            if (scramble && i == 3) begin
                op    = 6'b000100;
                funct = 6'b101010;
                zero  = 1'b1;
            end
            if (i == probe) begin
                check("probe_alucontrol", 32'(alucontrol), 32'(p_alu));
                check("probe_pcen",       32'(pcen),       32'(p_pcen));
            end
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'b0;
        funct = 6'b0;
        zero  = 1'b0;
        #1;
        check("rst_state",   32'(state),      32'd0);
        check("rst_pcen",    32'(pcen),       32'd1);
        check("rst_irwrite", 32'(irwrite),    32'd1);
        check("rst_alusrcb", 32'(alusrcb),    32'd1);
        check("rst_alu",     32'(alucontrol), 32'd2);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;

        run_instr(6'b100011, 6'b000000, 1'b0, 5, -1, 3'b010, 1'b0, 1'b0); // lw
        run_instr(6'b101011, 6'b000000, 1'b1, 4,  2, 3'b010, 1'b0, 1'b0); // sw
        run_instr(6'b000000, 6'b100010, 1'b0, 4,  2, 3'b110, 1'b0, 1'b0); // sub
        run_instr(6'b000000, 6'b101010, 1'b1, 4,  2, 3'b111, 1'b0, 1'b0); // slt
        run_instr(6'b000000, 6'b100000, 1'b0, 4, -1, 3'b010, 1'b0, 1'b0); // add
        run_instr(6'b000000, 6'b100100, 1'b0, 4,  2, 3'b000, 1'b0, 1'b0); // and
        run_instr(6'b000000, 6'b100101, 1'b0, 4,  2, 3'b001, 1'b0, 1'b0); // or
        run_instr(6'b000000, 6'b000111, 1'b0, 4,  2, 3'b010, 1'b0, 1'b0); // unknown funct
        run_instr(6'b001000, 6'b101010, 1'b0, 4, -1, 3'b010, 1'b0, 1'b0); // addi
        run_instr(6'b000100, 6'b000000, 1'b1, 3,  2, 3'b110, 1'b1, 1'b0); // beq taken
        run_instr(6'b000100, 6'b000000, 1'b0, 3,  2, 3'b110, 1'b0, 1'b0); // beq not taken
        run_instr(6'b000010, 6'b000000, 1'b0, 3,  2, 3'b010, 1'b1, 1'b0); // j
        run_instr(6'b111111, 6'b100010, 1'b1, 2, -1, 3'b010, 1'b0, 1'b0); // illegal
        run_instr(6'b100011, 6'b000000, 1'b0, 5, -1, 3'b010, 1'b0, 1'b1); // lw, inputs disturbed late

        // Reset in the middle of MEMRD, between clock edges
        op = 6'b100011;
        funct = 6'b0;
        zero = 1'b0;
        exp_q.push_back(S_FETCH);
        exp_q.push_back(S_DECODE);
        exp_q.push_back(S_MEMADR);
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        check("memrd_state", 32'(state), 32'd3);
        check("memrd_iord",  32'(iord),  32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_state",   32'(state),   32'd0);
        check("midrst_pcen",    32'(pcen),    32'd1);
        check("midrst_irwrite", 32'(irwrite), 32'd1);
        check("midrst_iord",    32'(iord),    32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;

        run_instr(6'b000000, 6'b100010, 1'b0, 4,  2, 3'b110, 1'b0, 1'b0);
        run_instr(6'b101011, 6'b000000, 1'b0, 4, -1, 3'b010, 1'b0, 1'b0);

        #10;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
